// File: rtl/mops_ctrl_pkg.sv
// Shared widths, flush defaults, state encoding and configuration bundle for
// the MoPS trigger control slice (the trigger-definition constants live here).
package mops_ctrl_pkg;

  localparam int ADC_WIDTH                   = 12;
  localparam int MOPS_OCC_WIDTH              = 5;
  localparam int COMPATIBILITY_INTEGRAL_BITS = 8;
  localparam int COMPATIBILITY_MOPS_OFS_BITS = 3;
  localparam int MOPS_FLUSH_LEN              = 121;
  localparam int MOPS_FLUSH_PAD              = 4;
  localparam int TRIG_COUNT_WIDTH            = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } mops_state_e;

  typedef struct packed {
    logic [2:0][ADC_WIDTH-1:0]                 min;
    logic [2:0][ADC_WIDTH-1:0]                 max;
    logic [MOPS_OCC_WIDTH-1:0]                 occupancy;
    logic [COMPATIBILITY_INTEGRAL_BITS-1:0]    integral;
    logic [COMPATIBILITY_MOPS_OFS_BITS-1:0]    ofs;
    logic [1:0]                                multiplicity;
    logic [2:0]                                trig_enable;
  } mops_cfg_t;

  localparam mops_cfg_t CFG_ZERO = '{
    min:          {3{{ADC_WIDTH{1'b0}}}},
    max:          {3{{ADC_WIDTH{1'b0}}}},
    occupancy:    {MOPS_OCC_WIDTH{1'b0}},
    integral:     {COMPATIBILITY_INTEGRAL_BITS{1'b0}},
    ofs:          {COMPATIBILITY_MOPS_OFS_BITS{1'b0}},
    multiplicity: 2'b00,
    trig_enable:  3'b000
  };

  function automatic logic [TRIG_COUNT_WIDTH-1:0] sat_inc(
    input logic [TRIG_COUNT_WIDTH-1:0] value
  );
    if (value == {TRIG_COUNT_WIDTH{1'b1}}) begin
      return value;
    end else begin
      return value + {{(TRIG_COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/mops_phase_gen.sv
// 40 MHz phase generator: counts 0,1,2 on the 120 MHz clock.
module mops_phase_gen (
  input  logic       CLK120,
  input  logic       RESET,
  output logic [1:0] ENABLE40
);

  logic [1:0] phase_r;

  // Phase counter with wrap from 2 back to 0.
  always_ff @(posedge CLK120) begin
    if (RESET) begin
      phase_r <= 2'd0;
    end else if (phase_r == 2'd2) begin
      phase_r <= 2'd0;
    end else begin
      phase_r <= phase_r + 2'd1;
    end
  end

  assign ENABLE40 = phase_r;

endmodule

// File: rtl/mops_ctrl.sv
// MoPS configuration sequencer: stages updates, applies them on the 40 MHz
// boundary, holds triggers off while the MoPS window flushes, then gates triggers.
module mops_ctrl
  import mops_ctrl_pkg::*;
#(
  parameter int FLUSH_LEN = MOPS_FLUSH_LEN,
  parameter int FLUSH_PAD = MOPS_FLUSH_PAD
) (
  input  logic                                   CLK120,
  input  logic                                   RESET,
  input  logic [ADC_WIDTH-1:0]                   CFG_MIN0,
  input  logic [ADC_WIDTH-1:0]                   CFG_MIN1,
  input  logic [ADC_WIDTH-1:0]                   CFG_MIN2,
  input  logic [ADC_WIDTH-1:0]                   CFG_MAX0,
  input  logic [ADC_WIDTH-1:0]                   CFG_MAX1,
  input  logic [ADC_WIDTH-1:0]                   CFG_MAX2,
  input  logic [MOPS_OCC_WIDTH-1:0]              CFG_OCCUPANCY,
  input  logic [COMPATIBILITY_INTEGRAL_BITS-1:0] CFG_INT,
  input  logic [COMPATIBILITY_MOPS_OFS_BITS-1:0] CFG_OFS,
  input  logic [1:0]                             CFG_MULTIPLICITY,
  input  logic [2:0]                             CFG_TRIG_ENABLE,
  input  logic                                   CFG_UPDATE,
  input  logic                                   TRIG_IN,
  output logic [1:0]                             ENABLE40,
  output logic [ADC_WIDTH-1:0]                   MIN0,
  output logic [ADC_WIDTH-1:0]                   MIN1,
  output logic [ADC_WIDTH-1:0]                   MIN2,
  output logic [ADC_WIDTH-1:0]                   MAX0,
  output logic [ADC_WIDTH-1:0]                   MAX1,
  output logic [ADC_WIDTH-1:0]                   MAX2,
  output logic [MOPS_OCC_WIDTH-1:0]              OCCUPANCY,
  output logic [COMPATIBILITY_INTEGRAL_BITS-1:0] INT,
  output logic [COMPATIBILITY_MOPS_OFS_BITS-1:0] OFS,
  output logic [1:0]                             MULTIPLICITY,
  output logic [2:0]                             TRIG_ENABLE,
  output logic                                   TRIG_OUT,
  output logic                                   BUSY,
  output logic [TRIG_COUNT_WIDTH-1:0]            TRIG_COUNT
);

  localparam int FLUSH_TOTAL = FLUSH_LEN + FLUSH_PAD;
  localparam int CNT_W       = (FLUSH_TOTAL > 0) ? $clog2(FLUSH_TOTAL + 1) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_TOTAL);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(1'b0);

  logic [1:0]                  enable40_s;
  logic                        slow_tick_s;
  logic                        apply_tick_s;
  mops_state_e                 state_r;
  mops_state_e                 state_s;
  logic [CNT_W-1:0]            flush_cnt_r;
  logic [CNT_W-1:0]            flush_cnt_s;
  logic                        apply_s;
  logic                        go_run_s;
  logic                        busy_r;
  mops_cfg_t                   cfg_in_s;
  mops_cfg_t                   stage_r;
  mops_cfg_t                   applied_r;
  logic                        trig_out_r;
  logic [TRIG_COUNT_WIDTH-1:0] trig_count_r;

  mops_phase_gen u_phase_gen (
    .CLK120   (CLK120),
    .RESET    (RESET),
    .ENABLE40 (enable40_s)
  );

  assign slow_tick_s  = (enable40_s == 2'd0);
  assign apply_tick_s = (enable40_s == 2'd2);

  assign cfg_in_s = '{
    min:          {CFG_MIN2, CFG_MIN1, CFG_MIN0},
    max:          {CFG_MAX2, CFG_MAX1, CFG_MAX0},
    occupancy:    CFG_OCCUPANCY,
    integral:     CFG_INT,
    ofs:          CFG_OFS,
    multiplicity: CFG_MULTIPLICITY,
    trig_enable:  CFG_TRIG_ENABLE
  };

  // State, flush counter and busy flag registers.
  always_ff @(posedge CLK120) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= CNT_ZERO;
      busy_r      <= 1'b1;
    end else begin
      state_r     <= state_s;
      flush_cnt_r <= flush_cnt_s;
      busy_r      <= (state_s != ST_RUN);
    end
  end

  // Next-state logic; a fresh update always wins over apply or run entry.
  always_comb begin
    state_s     = state_r;
    flush_cnt_s = flush_cnt_r;
    apply_s     = 1'b0;
    go_run_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_RUN: begin
        if (CFG_UPDATE) begin
          state_s = ST_PEND;
        end else begin
          state_s = state_r;
        end
      end
      ST_PEND: begin
        if (CFG_UPDATE) begin
          state_s = ST_PEND;
        end else if (apply_tick_s) begin
          apply_s     = 1'b1;
          flush_cnt_s = FLUSH_LOAD;
          state_s     = ST_FLUSH;
        end else begin
          state_s = ST_PEND;
        end
      end
      ST_FLUSH: begin
        if (CFG_UPDATE) begin
          state_s = ST_PEND;
        end else if (flush_cnt_r == CNT_ZERO) begin
          go_run_s = 1'b1;
          state_s  = ST_RUN;
        end else if (slow_tick_s) begin
          flush_cnt_s = flush_cnt_r - CNT_ONE;
        end else begin
          flush_cnt_s = flush_cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Staging captures every update; applied set takes it with triggers held off.
  always_ff @(posedge CLK120) begin
    if (RESET) begin
      stage_r   <= CFG_ZERO;
      applied_r <= CFG_ZERO;
    end else begin
      if (CFG_UPDATE) begin
        stage_r <= cfg_in_s;
      end else begin
        stage_r <= stage_r;
      end
      if (apply_s) begin
        applied_r             <= stage_r;
        applied_r.trig_enable <= 3'b000;
      end else if (go_run_s) begin
        applied_r.trig_enable <= stage_r.trig_enable;
      end else begin
        applied_r <= applied_r;
      end
    end
  end

  // Gated trigger and its saturating counter, cleared on each apply.
  always_ff @(posedge CLK120) begin
    if (RESET) begin
      trig_out_r   <= 1'b0;
      trig_count_r <= {TRIG_COUNT_WIDTH{1'b0}};
    end else begin
      trig_out_r <= TRIG_IN && (state_r == ST_RUN);
      if (apply_s) begin
        trig_count_r <= {TRIG_COUNT_WIDTH{1'b0}};
      end else if (trig_out_r) begin
        trig_count_r <= sat_inc(trig_count_r);
      end else begin
        trig_count_r <= trig_count_r;
      end
    end
  end

  assign ENABLE40     = enable40_s;
  assign MIN0         = applied_r.min[0];
  assign MIN1         = applied_r.min[1];
  assign MIN2         = applied_r.min[2];
  assign MAX0         = applied_r.max[0];
  assign MAX1         = applied_r.max[1];
  assign MAX2         = applied_r.max[2];
  assign OCCUPANCY    = applied_r.occupancy;
  assign INT          = applied_r.integral;
  assign OFS          = applied_r.ofs;
  assign MULTIPLICITY = applied_r.multiplicity;
  assign TRIG_ENABLE  = applied_r.trig_enable;
  assign TRIG_OUT     = trig_out_r;
  assign BUSY         = busy_r;
  assign TRIG_COUNT   = trig_count_r;

endmodule

// File: doc/mops_ctrl.md
MOPS_CTRL -- requirements
Module: mops_ctrl

Interface
REQ-001 Parameter FLUSH_LEN, default 121, SHALL set the number of 40 MHz ticks the MoPS window is flushed after a configuration change.
REQ-002 Parameter FLUSH_PAD, default 4, SHALL set the extra 40 MHz ticks added to the flush to cover trigger pipeline delay.
REQ-003 CLK120  in  1  SHALL be the single 120 MHz clock.
REQ-004 RESET  in  1  SHALL be synchronous, active-high reset.
REQ-005 CFG_MIN0..2, CFG_MAX0..2  in  `ADC_WIDTH each  SHALL be the staged step thresholds per PMT.
REQ-006 CFG_OCCUPANCY  in  `MOPS_OCC_WIDTH  SHALL be the staged occupancy threshold.
REQ-007 CFG_INT  in  `COMPATIBILITY_INTEGRAL_BITS  SHALL be the staged integral threshold.
REQ-008 CFG_OFS  in  `COMPATIBILITY_MOPS_OFS_BITS  SHALL be the staged veto offset.
REQ-009 CFG_MULTIPLICITY  in  2  SHALL be the staged multiplicity (0 = trigger off).
REQ-010 CFG_TRIG_ENABLE  in  3  SHALL be the staged per-PMT enable.
REQ-011 CFG_UPDATE  in  1  SHALL be a one-cycle pulse requesting that the staged values be applied.
REQ-012 TRIG_IN  in  1  SHALL be the raw trigger from the MoPS datapath.
REQ-013 ENABLE40  out  2  SHALL be the 40 MHz phase, 0,1,2,0,...
REQ-014 MIN0..2, MAX0..2, OCCUPANCY, INT, OFS, MULTIPLICITY, TRIG_ENABLE  out  same widths as CFG_*  SHALL be the applied configuration.
REQ-015 TRIG_OUT  out  1  SHALL be the gated trigger.
REQ-016 BUSY  out  1  SHALL be high whenever the state is not RUN.
REQ-017 TRIG_COUNT  out  16  SHALL be the saturating count of gated triggers since the last apply.

Function
REQ-018 ENABLE40 SHALL increment every CLK120 cycle and wrap from 2 to 0.
REQ-019 A "slow tick" SHALL be any cycle with ENABLE40==0.
REQ-020 States SHALL be IDLE, PEND, FLUSH and RUN.
REQ-021 Any CFG_UPDATE SHALL copy all CFG_* inputs into internal staging registers in the same cycle, in every state; with repeated updates, the last one wins.
REQ-022 From IDLE, RUN or FLUSH, a CFG_UPDATE SHALL move the machine to PEND.
REQ-023 In PEND, on the cycle ENABLE40==2, the staging registers SHALL be copied to the applied outputs, except TRIG_ENABLE, which SHALL be driven to 0; so new values are stable from the next ENABLE40==0.
REQ-024 On that same ENABLE40==2 cycle, the flush counter SHALL be loaded with FLUSH_LEN+FLUSH_PAD, TRIG_COUNT SHALL be cleared, and the state SHALL become FLUSH.
REQ-025 A CFG_UPDATE coinciding with the PEND apply cycle SHALL win: the state SHALL stay PEND and the apply SHALL happen at the next ENABLE40==2.
REQ-026 In FLUSH, the counter SHALL decrement once per slow tick.
REQ-027 When the counter reaches 0 in FLUSH, TRIG_ENABLE SHALL take the staged value on the next cycle and the state SHALL become RUN.
REQ-028 A CFG_UPDATE during FLUSH SHALL abandon the count, return to PEND, and restart the flush after the next apply.
REQ-029 TRIG_OUT SHALL equal TRIG_IN registered, gated by state==RUN, with 1-cycle latency.
REQ-030 TRIG_IN held high across several cycles SHALL pass through unmodified; the datapath already edge-filters.
REQ-031 TRIG_COUNT SHALL increment on each cycle TRIG_OUT is high and SHALL saturate at 16'hFFFF.
REQ-032 MULTIPLICITY==0 SHALL follow the same sequence; no special case is required.

Reset
REQ-033 RESET SHALL force state=IDLE, ENABLE40=0, all applied outputs=0, staging=0, flush counter=0, TRIG_OUT=0, TRIG_COUNT=0 and BUSY=1.
REQ-034 RESET asserted mid-flush or mid-pend SHALL discard the pending update; no apply SHALL occur after reset.

Structure
REQ-035 FLUSH_LEN default, `MOPS_OCC_WIDTH, `COMPATIBILITY_MOPS_OFS_BITS, `ADC_WIDTH and `COMPATIBILITY_INTEGRAL_BITS SHALL come from sde_trigger_defs.vh.
REQ-036 State encodings SHALL be added to sde_trigger_defs.vh.
REQ-037 A single sub-module, mops_phase_gen (ENABLE40 counter), SHALL be instantiated; everything else SHALL be flat.

Verification
REQ-038 Reset then 10 cycles with no update -> ENABLE40 cycles 0,1,2; BUSY=1; all outputs 0; TRIG_OUT=0 with TRIG_IN=1.
REQ-039 CFG_MIN0=30, CFG_MAX0=120, CFG_TRIG_ENABLE=3'b111, CFG_UPDATE issued at ENABLE40=0 -> MIN0=30 appears the cycle after ENABLE40==2; TRIG_ENABLE=0 for exactly 125 slow ticks, then 3'b111; BUSY falls with it.
REQ-040 In RUN, a 3-cycle TRIG_IN pulse -> TRIG_OUT 3 cycles, delayed 1; TRIG_COUNT=3. TRIG_IN during FLUSH -> TRIG_OUT=0; TRIG_COUNT unchanged.
REQ-041 CFG_UPDATE at flush tick 60 with CFG_OCCUPANCY changed 5->9 -> PEND, OCCUPANCY=9 after next ENABLE40==2, flush restarts at 125.
REQ-042 Two CFG_UPDATEs 1 cycle apart with MULTIPLICITY 1 then 2 -> applied MULTIPLICITY=2; single flush.
REQ-043 RESET pulsed at flush tick 10 -> IDLE, all outputs 0; no later apply without a new CFG_UPDATE.
